cpu_clock_gen: RTL
==================

# cpu_clock_gen

Parametrised CPU clock generator. It replaces the fixed divide-by-2 turbo clock and the single-jumper speed switch with a table of 2^SEL_W selectable speeds. It synchronises and debounces a multi-bit speed select. A new speed is applied only between bus cycles and only at a clock-period boundary, so CLKCPU never glitches. It sits between the PLL and the CPU clock pin, beside the bus-synchronisation and fast-DTACK logic.

## Interface
Parameters:
- SEL_W, 2: speed-select width; 2^SEL_W speed codes.
- DIV_W, 4: divisor width.
- DIV_TABLE, {4'd8,4'd4,4'd3,4'd2}: packed divisors, DIV_W bits per code, code 0 in the LSBs. A divisor below 2 is treated as 2.
- DEBOUNCE_CYCLES, 2000000: stability time before a select change is accepted (20 ms at 100 MHz).

Ports:
- pll_inst1_CLKOUT0, in, 1: sole clock.
- RESET_n, in, 1: reset, asynchronous, active-low.
- SPEED_SEL, in, SEL_W: raw jumper/switch speed code; asynchronous.
- BUS_IDLE, in, 1: AS_CPU_n & DTACK_CPU_n, i.e. CPU in S7/idle; asynchronous.
- C7M, in, 1: motherboard 7 MHz. Present only with CPUCLK_C7M_EN.
- CLKCPU, out, 1: registered CPU clock.
- SPEED_ACTIVE, out, SEL_W: code currently driving CLKCPU.
- SWITCH_PENDING, out, 1: a debounced target differs from the active code.

## Operation
- Reset values: CLKCPU=1, SPEED_ACTIVE=0, SWITCH_PENDING=0, target=0, candidate=0, debounce count=0, divider cnt=0, FSM=RUN.
- Synchronisers: SPEED_SEL and BUS_IDLE each pass through two flops; all logic uses the synchronised copies.
- Debounce:
  - If sel_s != candidate: candidate<=sel_s and count<=0.
  - Otherwise count increments, saturating at DEBOUNCE_CYCLES.
  - When count==DEBOUNCE_CYCLES: target<=candidate.
  - Shorter pulses are discarded.
- Divider, divisor d = DIV_TABLE[active]:
  - cnt runs 0..d-1 and wraps.
  - CLKCPU<=1 for cnt<d/2 (floor), else 0. Odd d gives a longer low phase; d=3 gives 1 high cycle and 2 low.
  - Terminal count is cnt==d-1, the last low cycle.
- FSM:
  - RUN: if target!=active, go to WAIT_IDLE.
  - WAIT_IDLE:
    - If target==active, go to RUN (cancelled).
    - Else if bus_idle_s, go to WAIT_EDGE.
  - WAIT_EDGE:
    - If !bus_idle_s, go to WAIT_IDLE.
    - Else if target==active, go to RUN.
    - Else at terminal count: active<=target, cnt<=0, go to RUN.
- SWITCH_PENDING = (state != RUN).
- If target changes again while pending, the newest target is applied; no queueing.
- Reset mid-switch: everything returns to reset values immediately; CLKCPU goes high asynchronously.

## Timing
- CLKCPU comes straight from a flop on posedge pll_inst1_CLKOUT0. No combinational path to the pin.
- Select-to-switch latency: 2 sync + 1 compare + DEBOUNCE_CYCLES + 1, then the idle wait, then at most d_old cycles to reach the terminal count.
- After a switch, the first new-speed high phase starts on the next clock edge. No period is shorter than min(d_old, d_new) cycles, and no high or low phase is shorter than 1 cycle.
- BUS_IDLE deasserting while in WAIT_EDGE aborts the switch. The old divisor continues unchanged.

## Configuration
- CPUCLK_C7M_EN defined:
  - Port C7M is present.
  - Code 2^SEL_W-1 selects follow mode: CLKCPU <= C7M after a 2-flop sync, with jitter of ±1 CLKOUT0 cycle.
  - Entering follow mode: requires terminal count AND synced C7M low.
  - Leaving follow mode: occurs on the synced C7M falling edge, with cnt<=0.
  - DIV_TABLE's top entry is ignored.
- CPUCLK_C7M_EN undefined: no C7M port; every code, including the top one, uses DIV_TABLE.

## Test plan
- Reset with DIV_TABLE default, SEL=0 -> CLKCPU toggles every cycle (period 2), SPEED_ACTIVE=0, SWITCH_PENDING=0.
- DEBOUNCE_CYCLES=16, SEL 0->1 with BUS_IDLE=1 held -> SWITCH_PENDING rises about 19 cycles later; switch occurs at the next terminal count; period becomes 4 (2 high / 2 low); SPEED_ACTIVE=1.
- SEL pulses to 2 for 10 cycles (DEBOUNCE_CYCLES=16) -> no target change, SWITCH_PENDING stays 0.
- SEL->2 with BUS_IDLE=0 for 100 cycles, then 1 -> period 4 holds throughout; switch happens only after idle; new period is 3 (1 high / 2 low); every phase is at least 1 cycle.
- In WAIT_EDGE, drop BUS_IDLE one cycle before terminal count -> no switch, state WAIT_IDLE; switch completes after idle returns.
- With CPUCLK_C7M_EN, SEL=3 -> CLKCPU tracks C7M 2–3 cycles late; return to SEL=0 happens at a C7M fall with no runt pulse. Assert RESET_n low mid-WAIT_EDGE -> all outputs at reset values.

Source files
------------

// File: rtl/cpu_clock_gen_if.sv
// -----------------------------------------------------------------------------
// cpu_clock_gen_if
// Groups the speed-select and bus-state signals that pass between the board
// logic and the CPU clock generator.
//
// Signals:
//   SPEED_SEL      - raw jumper/switch speed code (asynchronous)
//   BUS_IDLE       - AS_CPU_n & DTACK_CPU_n, CPU idle (asynchronous)
//   CLKCPU         - registered CPU clock
//   SPEED_ACTIVE   - speed code currently driving CLKCPU
//   SWITCH_PENDING - a debounced target differs from the active code
//
// Modports:
//   master - board side: drives the select and bus state, observes the clock
//   slave  - clock generator side
// -----------------------------------------------------------------------------
interface cpu_clock_gen_if #(
    parameter int SEL_W = 2
);
    logic [SEL_W-1:0] SPEED_SEL;
    logic             BUS_IDLE;
    logic             CLKCPU;
    logic [SEL_W-1:0] SPEED_ACTIVE;
    logic             SWITCH_PENDING;

    modport master (
        output SPEED_SEL,
        output BUS_IDLE,
        input  CLKCPU,
        input  SPEED_ACTIVE,
        input  SWITCH_PENDING
    );

    modport slave (
        input  SPEED_SEL,
        input  BUS_IDLE,
        output CLKCPU,
        output SPEED_ACTIVE,
        output SWITCH_PENDING
    );
endinterface

// File: rtl/cpu_clock_gen.sv
// -----------------------------------------------------------------------------
// cpu_clock_gen
// CPU clock generator with 2^SEL_W selectable speeds. The speed select is
// synchronised and debounced; a new speed is applied only while the bus is
// idle and only at the end of a full clock period, so CLKCPU never glitches.
//
// Ports:
//   pll_inst1_CLKOUT0 - sole clock
//   RESET_n           - asynchronous, active-low reset
//   bus               - cpu_clock_gen_if.slave (SPEED_SEL, BUS_IDLE in;
//                       CLKCPU, SPEED_ACTIVE, SWITCH_PENDING out)
//   C7M               - motherboard 7 MHz clock (only with CPUCLK_C7M_EN)
//
// Optional feature macro: CPUCLK_C7M_EN
//   When defined, the top speed code makes CLKCPU follow a synchronised copy of
//   C7M and the top DIV_TABLE entry is ignored. When undefined, every code is
//   taken from DIV_TABLE.
// -----------------------------------------------------------------------------
module cpu_clock_gen #(
    parameter int                              SEL_W           = 2,
    parameter int                              DIV_W           = 4,
    parameter logic [(2**SEL_W)*DIV_W-1:0]     DIV_TABLE       = {4'd8, 4'd4, 4'd3, 4'd2},
    parameter int                              DEBOUNCE_CYCLES = 2000000
) (
    input  logic            pll_inst1_CLKOUT0,
    input  logic            RESET_n,
    cpu_clock_gen_if.slave  bus
`ifdef CPUCLK_C7M_EN
    ,
    input  logic            C7M
`endif
);

    localparam int               DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_MAX = DB_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        RUN,
        WAIT_IDLE,
        WAIT_EDGE
    } state_t;

    // Divisor for a code, clamped so every phase lasts at least one cycle.
    function automatic logic [DIV_W-1:0] div_of(input logic [SEL_W-1:0] code);
        logic [DIV_W-1:0] d;
        d = DIV_TABLE[code*DIV_W +: DIV_W];
        if (d < DIV_W'(2)) d = DIV_W'(2);
        return d;
    endfunction

    logic [SEL_W-1:0] sel_meta, sel_s;
    logic             idle_meta, idle_s;
    logic [SEL_W-1:0] candidate, target, active;
    logic [DB_W-1:0]  db_cnt;
    logic [DIV_W-1:0] cnt, cnt_inc, d_cur, half;
    logic             clk_q, clk_next, term, switch_ok, do_switch;
    state_t           state_q, state_d;

    // NOTE: every flop resets asynchronously so CLKCPU returns high the moment
    // RESET_n falls, even in the middle of a speed switch.
    always_ff @(posedge pll_inst1_CLKOUT0 or negedge RESET_n) begin
        if (!RESET_n) begin
            sel_meta  <= '0;
            sel_s     <= '0;
            idle_meta <= 1'b0;
            idle_s    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the two sync stages shift in
            // one edge instead of collapsing into a single flop.
            sel_meta  <= bus.SPEED_SEL;
            sel_s     <= sel_meta;
            idle_meta <= bus.BUS_IDLE;
            idle_s    <= idle_meta;
        end
    end

    // Debounce: a code must be stable for DEBOUNCE_CYCLES before it becomes
    // the target. While saturated the target keeps being refreshed, which is
    // harmless because the candidate has not changed.
    always_ff @(posedge pll_inst1_CLKOUT0 or negedge RESET_n) begin
        if (!RESET_n) begin
            candidate <= '0;
            db_cnt    <= '0;
            target    <= '0;
        end else begin
            if (sel_s != candidate) begin
                candidate <= sel_s;
                db_cnt    <= '0;
            end else if (db_cnt != DB_MAX) begin
                db_cnt <= db_cnt + 1'b1;
            end
            if (db_cnt == DB_MAX) target <= candidate;
        end
    end

    assign d_cur   = div_of(active);
    assign half    = d_cur >> 1;
    assign term    = (cnt >= d_cur - 1'b1);
    assign cnt_inc = term ? '0 : cnt + 1'b1;

`ifdef CPUCLK_C7M_EN
    localparam logic [SEL_W-1:0] FOLLOW_CODE = '1;

    logic c7m_meta, c7m_s, c7m_d;
    logic follow, c7m_fall;

    always_ff @(posedge pll_inst1_CLKOUT0 or negedge RESET_n) begin
        if (!RESET_n) begin
            c7m_meta <= 1'b0;
            c7m_s    <= 1'b0;
            c7m_d    <= 1'b0;
        end else begin
            c7m_meta <= C7M;
            c7m_s    <= c7m_meta;
            c7m_d    <= c7m_s;
        end
    end

    assign follow   = (active == FOLLOW_CODE);
    assign c7m_fall = c7m_d & ~c7m_s;

    // Leaving follow mode waits for a C7M fall; entering it waits for the end
    // of a divider period while C7M is low, so neither side produces a runt.
    assign switch_ok = follow ? c7m_fall
                              : (term && ((target != FOLLOW_CODE) || !c7m_s));

    always_comb begin
        clk_next = (cnt_inc < half);
        if (do_switch)   clk_next = (target == FOLLOW_CODE) ? c7m_s : 1'b1;
        else if (follow) clk_next = c7m_s;
    end
`else
    assign switch_ok = term;

    always_comb begin
        clk_next = (cnt_inc < half);
        if (do_switch) clk_next = 1'b1;
    end
`endif

    // Switch-control FSM: wait for the bus to go idle, then for a period
    // boundary. A newer target simply replaces the pending one.
    always_ff @(posedge pll_inst1_CLKOUT0 or negedge RESET_n) begin
        if (!RESET_n) state_q <= RUN;
        else          state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output
        // unassigned and infers a latch.
        state_d   = state_q;
        do_switch = 1'b0;
        case (state_q)
            RUN: begin
                if (target != active) state_d = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (target == active) state_d = RUN;
                else if (idle_s)      state_d = WAIT_EDGE;
            end
            WAIT_EDGE: begin
                if (!idle_s)                 state_d = WAIT_IDLE;
                else if (target == active)   state_d = RUN;
                else if (switch_ok) begin
                    do_switch = 1'b1;
                    state_d   = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Divider and output flop; CLKCPU tracks the phase of the next cnt value.
    always_ff @(posedge pll_inst1_CLKOUT0 or negedge RESET_n) begin
        if (!RESET_n) begin
            active <= '0;
            cnt    <= '0;
            clk_q  <= 1'b1;
        end else begin
            clk_q <= clk_next;
            if (do_switch) begin
                active <= target;
                cnt    <= '0;
            end else begin
`ifdef CPUCLK_C7M_EN
                cnt <= follow ? '0 : cnt_inc;
`else
                cnt <= cnt_inc;
`endif
            end
        end
    end

    assign bus.CLKCPU         = clk_q;
    assign bus.SPEED_ACTIVE   = active;
    assign bus.SWITCH_PENDING = (state_q != RUN);

endmodule
